// File: rtl/mux8_rr_scheduler.sv
// Round-robin arbiter owning an 8:1 mux select with bounded hold time.
// Grants pass through one idle turnaround cycle; output bit is registered.
module mux8_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       f
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       f_q, f_d;

  logic [2:0] win;
  logic [2:0] idx;
  logic       found;

  // First requester at or after ptr, wrapping mod 8
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    f_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          sel_d   = win;
          gnt_d   = 8'b1 << win;
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      S_GRANT: begin
        if (req[sel_q] && (cnt_q < MAX_CNT)) begin
          cnt_d = cnt_q + 4'd1;
          f_d   = data_in[sel_q];
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      f_q     <= f_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign f    = f_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: directed scenarios plus random traffic
// compared against a behavioural arbitration model.
module tb_mux8_rr_scheduler;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       f;

  int vectors;
  int miscompares;

  // model state
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_held;
  bit m_f;
  int grant_log[$];

  mux8_rr_scheduler #(.MAX_HOLD(MAXH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data_in(data_in),
    .sel    (sel),
    .gnt    (gnt),
    .busy   (busy),
    .f      (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = m_busy ? (8'b1 << m_sel) : 8'h00;
    return {3'(m_sel), g, m_busy, m_f};
  endfunction

  // One clock edge: advance the model with the inputs seen at that edge
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_f = 0;
    end else if (!m_busy) begin
      m_f = 0;
      if (req != 0) begin
        for (int o = 0; o < 8; o++) begin
          if (req[(m_ptr + o) % 8]) begin
            m_sel = (m_ptr + o) % 8;
            break;
          end
        end
        m_busy = 1;
        m_held = 1;
        grant_log.push_back(m_sel);
      end
    end else begin
      if (req[m_sel] && m_held < MAXH) begin
        m_held++;
        m_f = data_in[m_sel];
      end else begin
        m_busy = 0;
        m_f    = 0;
        m_ptr  = (m_sel + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    data_in = 8'hFF;
    cyc();
    cyc();
    vectors++;
    if ({sel, gnt, busy, f} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got sel=%0d gnt=%h busy=%b f=%b want all zero",
               sel, gnt, busy, f);
    end
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: got gnt=%h sel=%0d busy=%b want 01/0/1",
               gnt, sel, busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] pat[10];
    pat = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00,
            8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
    do_reset();
    req = 8'h08;
    for (int i = 0; i < 10; i++) begin
      data_in = {4'h0, i[0], 3'b000};
      cyc();
      vectors++;
      if (gnt !== pat[i] || {sel, gnt, busy, f} !== exp_vec()) begin
        miscompares++;
        $display("FAIL single_req[%0d]: got sel=%0d gnt=%h busy=%b f=%b want %h gnt=%h",
                 i, sel, gnt, busy, f, exp_vec(), pat[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    grant_log.delete();
    req = 8'h81;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'($urandom);
      cyc();
      vectors++;
      if ({sel, gnt, busy, f} !== exp_vec()) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: got %h want %h",
                 i, {sel, gnt, busy, f}, exp_vec());
      end
    end
    vectors++;
    if (grant_log.size() < 3 || grant_log[0] != 0 ||
        grant_log[1] != 7 || grant_log[2] != 0) begin
      miscompares++;
      $display("FAIL round_robin_order: got %p want 0,7,0", grant_log);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 8'h24;
    data_in = 8'h04;
    cyc();
    cyc();
    req = 8'h20;
    cyc();
    vectors++;
    if (busy !== 1'b0 || gnt !== 8'h00) begin
      miscompares++;
      $display("FAIL early_release: got busy=%b gnt=%h want 0/00", busy, gnt);
    end
    cyc();
    vectors++;
    if (gnt !== 8'h20 || sel !== 3'd5 || {sel, gnt, busy, f} !== exp_vec()) begin
      miscompares++;
      $display("FAIL early_next_grant: got gnt=%h sel=%0d want 20/5", gnt, sel);
    end
  endtask

  task automatic test_reset_mid_grant();
    rst_n = 1'b0;
    req = 8'h21;
    cyc();
    vectors++;
    if ({sel, gnt, busy, f} !== 13'h0) begin
      miscompares++;
      $display("FAIL mid_grant_reset: got sel=%0d gnt=%h busy=%b f=%b want zero",
               sel, gnt, busy, f);
    end
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_grant_regrant: got gnt=%h sel=%0d want 01/0", gnt, sel);
    end
  endtask

  task automatic test_idle();
    logic [2:0] held_sel;
    do_reset();
    req = 8'h40;
    data_in = 8'hFF;
    cyc();
    req = 8'h00;
    cyc();
    held_sel = 3'd6;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'($urandom);
      cyc();
      vectors++;
      if (busy !== 1'b0 || gnt !== 8'h00 || f !== 1'b0 || sel !== held_sel) begin
        miscompares++;
        $display("FAIL idle[%0d]: got sel=%0d gnt=%h busy=%b f=%b want sel=%0d idle",
                 i, sel, gnt, busy, f, held_sel);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 79) != 0);
      req     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom & $urandom);
      data_in = 8'($urandom);
      cyc();
      vectors++;
      if ({sel, gnt, busy, f} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got sel=%0d gnt=%h busy=%b f=%b want %h",
                 i, sel, gnt, busy, f, exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req = 8'h00;
    data_in = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_reset_mid_grant();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
